// File: rtl/alu_acc.sv
// alu_acc: accumulator ALU with single-cycle logic/arithmetic ops and
// iterative (one bit per enabled clock) signed multiply and divide.
//
// Ports:
//   clock, reset_n   - rising-edge clock, asynchronous active-low reset
//   enable           - clock enable; all state holds while low
//   start, cmd       - command request and 4-bit opcode
//   operand          - signed second operand
//   acc_out          - signed accumulator
//   busy, done       - multi-cycle op in progress, one-cycle completion pulse
//   zero, neg, ovf, dbz - result flags, updated on each completion
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a command; single-cycle ops finish here
// ITER  | MUL/DIV in progress, one shift-add/subtract step per edge
module alu_acc #(
  parameter int WIDTH = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    start,
  input  logic [3:0]              cmd,
  input  logic signed [WIDTH-1:0] operand,
  output logic signed [WIDTH-1:0] acc_out,
  output logic                    busy,
  output logic                    done,
  output logic                    zero,
  output logic                    neg,
  output logic                    ovf,
  output logic                    dbz
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, ITER} state_t;

  state_t           state;
  logic             done_r;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi;      // MUL: product high half / DIV: remainder
  logic [WIDTH-1:0] lo;      // MUL: multiplier, product low half / DIV: dividend, quotient
  logic [WIDTH-1:0] mcand;   // MUL: multiplicand magnitude / DIV: divisor magnitude
  logic             op_div;
  logic             res_neg; // operand signs differ: negate the magnitude result

  // Single-cycle result
  logic signed [WIDTH-1:0] sc_res;
  logic                    sc_ovf;
  logic                    sc_dbz;
  logic                    sc_iter;

  always_comb begin
    sc_res  = acc_out;
    sc_ovf  = 1'b0;
    sc_dbz  = 1'b0;
    sc_iter = 1'b0;
    case (cmd)
      4'd1: begin
        sc_res = acc_out + operand;
        sc_ovf = (acc_out[WIDTH-1] == operand[WIDTH-1]) && (sc_res[WIDTH-1] != acc_out[WIDTH-1]);
      end
      4'd2: begin
        sc_res = acc_out - operand;
        sc_ovf = (acc_out[WIDTH-1] != operand[WIDTH-1]) && (sc_res[WIDTH-1] != acc_out[WIDTH-1]);
      end
      4'd3: sc_iter = 1'b1;
      4'd4: begin
        if (operand == '0) sc_dbz  = 1'b1;
        else               sc_iter = 1'b1;
      end
      4'd5: begin
        sc_res = -acc_out;
        sc_ovf = (acc_out == MOST_NEG);
      end
      4'd6: sc_res = acc_out & operand;
      4'd7: sc_res = acc_out | operand;
      4'd8: sc_res = acc_out ^ operand;
      4'd9: sc_res = operand;
      default: ;
    endcase
  end

  // Magnitudes; the most-negative value maps to 2^(WIDTH-1), which still fits unsigned.
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_mag = acc_out[WIDTH-1] ? WIDTH'(-acc_out) : acc_out;
  assign b_mag = operand[WIDTH-1] ? WIDTH'(-operand) : operand;

  // One iteration step
  logic [WIDTH:0]   mul_sum, div_diff;
  logic [WIDTH-1:0] div_shift, hi_nx, lo_nx;

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    div_shift = {hi[WIDTH-2:0], lo[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {1'b0, mcand};
    if (op_div) begin
      hi_nx = div_diff[WIDTH] ? div_shift : div_diff[WIDTH-1:0];
      lo_nx = {lo[WIDTH-2:0], ~div_diff[WIDTH]};
    end else begin
      hi_nx = mul_sum[WIDTH:1];
      lo_nx = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  // Final signed result from the last step
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   fin_res;
  logic               fin_ovf;

  always_comb begin
    prod_s = res_neg ? -{hi_nx, lo_nx} : {hi_nx, lo_nx};
    quo_s  = res_neg ? -lo_nx : lo_nx;
    if (op_div) begin
      fin_res = quo_s;
      // only a positive quotient of 2^(WIDTH-1) can fail to fit
      fin_ovf = ~res_neg & lo_nx[WIDTH-1];
    end else begin
      fin_res = prod_s[WIDTH-1:0];
      fin_ovf = ~((&prod_s[2*WIDTH-1:WIDTH-1]) | ~(|prod_s[2*WIDTH-1:WIDTH-1]));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      acc_out <= '0;
      busy    <= 1'b0;
      done_r  <= 1'b0;
      zero    <= 1'b1;
      neg     <= 1'b0;
      ovf     <= 1'b0;
      dbz     <= 1'b0;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      mcand   <= '0;
      op_div  <= 1'b0;
      res_neg <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (enable) begin
        case (state)
          IDLE: begin
            if (start) begin
              if (sc_iter) begin
                state   <= ITER;
                busy    <= 1'b1;
                cnt     <= '0;
                hi      <= '0;
                op_div  <= (cmd == 4'd4);
                res_neg <= acc_out[WIDTH-1] ^ operand[WIDTH-1];
                lo      <= (cmd == 4'd4) ? a_mag : b_mag;
                mcand   <= (cmd == 4'd4) ? b_mag : a_mag;
              end else begin
                acc_out <= sc_res;
                zero    <= (sc_res == '0);
                neg     <= sc_res[WIDTH-1];
                ovf     <= sc_ovf;
                dbz     <= sc_dbz;
                done_r  <= 1'b1;
              end
            end
          end
          ITER: begin
            hi  <= hi_nx;
            lo  <= lo_nx;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
              state   <= IDLE;
              busy    <= 1'b0;
              done_r  <= 1'b1;
              acc_out <= fin_res;
              zero    <= (fin_res == '0);
              neg     <= fin_res[WIDTH-1];
              ovf     <= fin_ovf;
              dbz     <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // done is forced low whenever the block is disabled
  assign done = done_r & enable;

endmodule

// File: tb/tb_alu_acc.sv
// tb_alu_acc: directed-vector bench for alu_acc (WIDTH=16) with
// hand-computed expected values.
module tb_alu_acc;

  logic               clock;
  logic               reset_n;
  logic               enable;
  logic               start;
  logic [3:0]         cmd;
  logic signed [15:0] operand;
  logic signed [15:0] acc_out;
  logic               busy, done, zero, neg, ovf, dbz;

  int n_vec = 0;
  int n_err = 0;

  alu_acc #(.WIDTH(16)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .start(start),
    .cmd(cmd), .operand(operand), .acc_out(acc_out), .busy(busy),
    .done(done), .zero(zero), .neg(neg), .ovf(ovf), .dbz(dbz)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [3:0] NOP = 4'd0, ADD = 4'd1, SUB = 4'd2, MUL = 4'd3, DIV = 4'd4,
                         NEG = 4'd5, LOAD = 4'd9;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns at the negedge just after the accept edge.
  task automatic issue(input logic [3:0] c, input logic [15:0] op);
    @(negedge clock);
    start = 1'b1; cmd = c; operand = op;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Waits for done, counting negedges (lat) and busy-high negedges.
  // Optionally drops enable for 3 cycles at dis_at, injects a start at inj_at.
  task automatic wait_done(input int dis_at, input int inj_at, output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    while (!done && lat < 60) begin
      if (busy) bcnt++;
      if (inj_at >= 0 && lat == inj_at) begin
        start = 1'b1; cmd = LOAD; operand = 16'd1;
      end
      if (inj_at >= 0 && lat == inj_at + 1) start = 1'b0;
      if (dis_at >= 0 && lat == dis_at) enable = 1'b0;
      if (dis_at >= 0 && lat == dis_at + 3) enable = 1'b1;
      @(negedge clock);
      lat++;
    end
    start = 1'b0;
    enable = 1'b1;
  endtask

  int lat, bcnt, dcnt;

  initial begin
    reset_n = 1'b0; enable = 1'b1; start = 1'b0; cmd = NOP; operand = '0;
    repeat (3) @(negedge clock);
    check_val("rst_acc", acc_out, 16'd0);
    check_val("rst_busy", 16'(busy), 16'd0);
    check_val("rst_done", 16'(done), 16'd0);
    check_val("rst_zero", 16'(zero), 16'd1);
    check_val("rst_flags", {12'd0, neg, ovf, dbz, 1'b0}, 16'd0);
    reset_n = 1'b1;

    // LOAD 50, ADD 32
    issue(LOAD, 16'd50);
    check_val("load_acc", acc_out, 16'd50);
    check_val("load_done", 16'(done), 16'd1);
    check_val("load_busy", 16'(busy), 16'd0);
    @(negedge clock);
    check_val("load_done_pulse", 16'(done), 16'd0);
    issue(ADD, 16'd32);
    check_val("add_acc", acc_out, 16'd82);
    check_val("add_done", 16'(done), 16'd1);
    check_val("add_busy", 16'(busy), 16'd0);
    check_val("add_flags", {12'd0, zero, neg, ovf, dbz}, 16'd0);
    @(negedge clock);
    check_val("add_done_pulse", 16'(done), 16'd0);

    // SUB 5, MUL 9 with an ignored start mid-operation
    issue(SUB, 16'd5);
    check_val("sub_acc", acc_out, 16'd77);
    issue(MUL, 16'd9);
    check_val("mul_busy", 16'(busy), 16'd1);
    check_val("mul_nodone", 16'(done), 16'd0);
    wait_done(-1, 3, lat, bcnt);
    check_val("mul_lat", 16'(lat), 16'd16);
    check_val("mul_busycnt", 16'(bcnt), 16'd16);
    check_val("mul_acc", acc_out, 16'd693);
    check_val("mul_busy_end", 16'(busy), 16'd0);
    @(negedge clock);
    check_val("mul_ignored_start", acc_out, 16'd693);
    check_val("mul_done_pulse", 16'(done), 16'd0);

    // DIV 0, then DIV 7
    issue(DIV, 16'd0);
    check_val("div0_done", 16'(done), 16'd1);
    check_val("div0_acc", acc_out, 16'd693);
    check_val("div0_dbz", 16'(dbz), 16'd1);
    check_val("div0_ovf", 16'(ovf), 16'd0);
    issue(DIV, 16'd7);
    wait_done(-1, -1, lat, bcnt);
    check_val("div7_lat", 16'(lat), 16'd16);
    check_val("div7_acc", acc_out, 16'd99);
    check_val("div7_dbz", 16'(dbz), 16'd0);

    // Overflow cases
    issue(LOAD, 16'd32767);
    issue(ADD, 16'd1);
    check_val("addovf_acc", acc_out, 16'h8000);
    check_val("addovf_flags", {12'd0, zero, neg, ovf, dbz}, 16'b0110);
    issue(DIV, 16'hFFFF);
    wait_done(-1, -1, lat, bcnt);
    check_val("divovf_acc", acc_out, 16'h8000);
    check_val("divovf_ovf", 16'(ovf), 16'd1);
    issue(NEG, 16'd0);
    check_val("negovf_acc", acc_out, 16'h8000);
    check_val("negovf_ovf", 16'(ovf), 16'd1);

    // Signed MUL / DIV
    issue(LOAD, 16'(-300));
    issue(MUL, 16'(-7));
    wait_done(-1, -1, lat, bcnt);
    check_val("mulneg_acc", acc_out, 16'd2100);
    check_val("mulneg_ovf", 16'(ovf), 16'd0);
    issue(MUL, 16'd100);
    wait_done(-1, -1, lat, bcnt);
    check_val("mulbig_acc", acc_out, 16'h3450);
    check_val("mulbig_ovf", 16'(ovf), 16'd1);
    issue(LOAD, 16'(-100));
    issue(DIV, 16'd7);
    wait_done(-1, -1, lat, bcnt);
    check_val("divneg_acc", acc_out, 16'(-14));
    check_val("divneg_neg", 16'(neg), 16'd1);
    issue(4'd12, 16'd5);
    check_val("op12_nop", acc_out, 16'(-14));
    check_val("op12_done", 16'(done), 16'd1);

    // MUL with enable low for 3 cycles
    issue(LOAD, 16'd12);
    issue(MUL, 16'(-11));
    wait_done(4, -1, lat, bcnt);
    check_val("mulen_lat", 16'(lat), 16'd19);
    check_val("mulen_busycnt", 16'(bcnt), 16'd19);
    check_val("mulen_acc", acc_out, 16'(-132));

    // Reset mid-MUL
    issue(LOAD, 16'd5);
    issue(MUL, 16'd3);
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_val("rstmid_acc", acc_out, 16'd0);
    check_val("rstmid_busy", 16'(busy), 16'd0);
    check_val("rstmid_zero", 16'(zero), 16'd1);
    @(negedge clock);
    reset_n = 1'b1;
    dcnt = 0;
    repeat (20) begin
      @(negedge clock);
      if (done) dcnt++;
    end
    check_val("rstmid_nodone", 16'(dcnt), 16'd0);
    issue(LOAD, 16'd7);
    check_val("rst_after_load", acc_out, 16'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_acc.md
ALU_ACC -- requirements
Module: alu_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the data path width in bits (legal range 8 to 32).
REQ-002 SHALL have port clock, input, 1 bit: single clock, and every register SHALL update on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port enable, input, 1 bit: global clock-enable; when low, all state holds.
REQ-005 SHALL have port start, input, 1 bit: command request.
REQ-006 SHALL have port cmd, input, 4 bits: opcode.
REQ-007 SHALL have port operand, input, WIDTH bits: signed second operand.
REQ-008 SHALL have port acc_out, output, WIDTH bits: signed accumulator register.
REQ-009 SHALL have port busy, output, 1 bit: a multi-cycle operation is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have ports zero, neg, ovf and dbz, outputs, 1 bit each: result flags.

Function
REQ-012 SHALL accept a command on a rising edge where start=1, enable=1 and busy=0, and SHALL ignore start on any other edge (no queuing).
REQ-013 SHALL decode cmd as: 0 NOP, 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5 NEG (acc = -acc), 6 AND, 7 OR, 8 XOR, 9 LOAD (acc = operand); codes 10-15 SHALL behave as NOP.
REQ-014 SHALL complete NOP, ADD, SUB, NEG, AND, OR, XOR and LOAD on the accept edge, and SHALL assert done for exactly the following cycle.
REQ-015 SHALL perform ADD and SUB in two's complement, wrap the result to WIDTH bits, and set ovf=1 on signed overflow.
REQ-016 SHALL set ovf=1 for NEG of the most-negative value and leave the result equal to that value.
REQ-017 SHALL implement MUL as an iterative signed shift-add: busy=1 from the accept edge through WIDTH further edges; acc_out updates on accept edge + WIDTH; busy falls and done is high for the cycle after that edge.
REQ-018 SHALL write the low WIDTH bits of the MUL product to acc_out and set ovf=1 when the full product is not representable in WIDTH signed bits.
REQ-019 SHALL implement DIV as an iterative restoring divide with the same WIDTH-cycle latency as MUL, producing a signed quotient truncated toward zero and discarding the remainder.
REQ-020 SHALL, for DIV with operand=0, complete in a single cycle with acc unchanged, dbz=1 and ovf=0.
REQ-021 SHALL, for DIV of the most-negative value by -1, write the most-negative value and set ovf=1.
REQ-022 SHALL, on each completion, set zero=(acc_out==0) and neg=acc_out[WIDTH-1], clear dbz unless REQ-020 applies, and clear ovf unless an overflow rule applies; flags SHALL hold between completions.
REQ-023 SHALL, while enable=0, freeze the iteration counter, partial results, busy and flags; done SHALL be 0 throughout; operation resumes when enable returns to 1, extending latency by the number of disabled cycles.
REQ-024 SHALL latch operand and cmd at accept, so that input changes during busy have no effect.
REQ-025 SHALL use exactly two control states, IDLE and ITER: IDLE->ITER on accept of MUL, or of DIV with nonzero operand; ITER->IDLE once the counter reaches WIDTH.

Reset
REQ-026 SHALL, while reset_n=0, immediately force acc_out=0, busy=0, done=0, ovf=0, dbz=0, neg=0, zero=1 and state=IDLE, independent of clock.
REQ-027 SHALL, on reset asserted during ITER, abort the operation with no done pulse and no partial write, and accept a new command on the first enabled edge after release.

Verification
REQ-028 SHALL cover, with WIDTH=16: reset, LOAD 50, ADD 32 -> acc_out=82, one done pulse per command, busy never high.
REQ-029 SHALL cover: SUB 5 then MUL 9 -> 77, then 693 after 16 busy cycles; a start issued mid-MUL is ignored.
REQ-030 SHALL cover: DIV 0 -> acc_out 693 unchanged, dbz=1 and done the next cycle; then DIV 7 -> 99 and dbz=0.
REQ-031 SHALL cover: LOAD 32767, ADD 1 -> acc_out=-32768, ovf=1, neg=1; then DIV -1 -> -32768, ovf=1.
REQ-032 SHALL cover: MUL with enable low for 3 mid-iteration cycles -> done 19 cycles after accept and a correct product.
REQ-033 SHALL cover: reset_n pulsed low mid-MUL -> acc_out=0, busy=0 and zero=1 immediately, and no done pulse.
